// File: rtl/adder32.sv
// 32-bit add datapath for the X-RISC ALU: eight 4-bit lookahead groups with
// rippled group carries, one register stage for the sum, carry, overflow and zero flags.

module adder32_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] p, g, c;
   logic       grp_p, grp_g;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

   assign grp_p = &p;
   assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

   assign co = grp_g | (grp_p & ci);
   assign s  = p ^ c;
endmodule

module adder32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c,
   output logic        C_out,
   output logic        overflow,
   output logic        zero,
   output logic        out_valid
);
   localparam int GROUPS = 8;

   logic [GROUPS:0]        gc;
   logic [GROUPS-1:0][3:0] gs;
   logic [31:0]            sum;
   logic                   ovf_nxt;

   assign gc[0] = 1'b0;

   for (genvar i = 0; i < GROUPS; i++) begin : g_grp
      adder32_cla4 u_grp (
         .a  (a[4*i +: 4]),
         .b  (b[4*i +: 4]),
         .ci (gc[i]),
         .s  (gs[i]),
         .co (gc[i+1])
      );
   end

   assign sum = gs;
   // carry into bit 31 is recovered from the sum bit itself: s31 ^ a31 ^ b31
   assign ovf_nxt = sum[31] ^ a[31] ^ b[31] ^ gc[GROUPS];

   always_ff @(posedge clk) begin
      if (rst) begin
         c         <= '0;
         C_out     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            c        <= sum;
            C_out    <= gc[GROUPS];
            overflow <= ovf_nxt;
            zero     <= (sum == 32'd0);
         end
      end
   end
endmodule

// File: tb/tb_adder32.sv
// Directed and random checks of adder32 against a 33-bit reference sum,
// with expected results queued at drive time and popped one cycle later.

module tb_adder32;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a, b;
   logic [31:0] c;
   logic        C_out, overflow, zero, out_valid;

   typedef struct {
      logic [31:0] c;
      logic        co;
      logic        ovf;
      logic        z;
   } res_t;

   res_t sb_q[$];
   res_t hold;
   int   checks = 0;
   int   passed = 0;

   adder32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .C_out     (C_out),
      .overflow  (overflow),
      .zero      (zero),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic res_t ref_add(input logic [31:0] x, input logic [31:0] y);
      res_t r;
      logic [32:0] full;
      full  = {1'b0, x} + {1'b0, y};
      r.c   = full[31:0];
      r.co  = full[32];
      r.ovf = (x[31] == y[31]) && (full[31] != x[31]);
      r.z   = (full[31:0] == 32'd0);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // one clock: drive at negedge, sample 1 time unit after the rising edge
   task automatic cyc(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y);
      res_t e;
      @(negedge clk);
      rst = r; in_valid = v; a = x; b = y;
      if (!r && v) sb_q.push_back(ref_add(x, y));
      @(posedge clk);
      #1;
      if (r) begin
         hold = '{32'd0, 1'b0, 1'b0, 1'b1};
         chk("rst_valid", {31'd0, out_valid}, 32'd0);
      end else if (v) begin
         chk("valid", {31'd0, out_valid}, 32'd1);
         if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            hold = e;
         end
      end else begin
         chk("idle_valid", {31'd0, out_valid}, 32'd0);
      end
      chk("c", c, hold.c);
      chk("C_out", {31'd0, C_out}, {31'd0, hold.co});
      chk("overflow", {31'd0, overflow}, {31'd0, hold.ovf});
      chk("zero", {31'd0, zero}, {31'd0, hold.z});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      hold = '{32'd0, 1'b0, 1'b0, 1'b1};

      cyc(1, 1, 32'h12345678, 32'h0);
      cyc(1, 1, 32'h12345678, 32'h0);

      cyc(0, 1, 32'hFFFFFFFF, 32'h0);
      cyc(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      cyc(0, 1, 32'h00000001, 32'hFFFFFFFF);
      cyc(0, 1, 32'h80000000, 32'hFFFFFFFF);
      cyc(0, 1, 32'h80000000, 32'h80000000);
      cyc(0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF);
      // fixed-constant spot checks, independent of the reference function
      chk("7fff_sum", c, 32'hFFFFFFFE);
      chk("7fff_ovf", {31'd0, overflow}, 32'd1);

      cyc(0, 1, 32'h0, 32'h0);
      cyc(0, 1, 32'h80000000, 32'h0);
      cyc(0, 1, 32'd5, 32'd7);
      cyc(0, 0, 32'hDEADBEEF, 32'h1);
      chk("hold_c", c, 32'h0000000C);

      // reset in the middle of a stream drops the result in flight
      cyc(0, 1, 32'h11111111, 32'h22222222);
      cyc(1, 1, 32'h33333333, 32'h44444444);
      cyc(0, 0, 32'h0, 32'h0);
      cyc(0, 1, 32'h0000FFFF, 32'h00000001);

      for (int i = 0; i < 10000; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom();
         rb = $urandom();
         case ($urandom_range(0, 7))
            0: rb = ~ra + 32'd1;
            1: ra = 32'h80000000;
            default: ;
         endcase
         cyc(0, ($urandom_range(0, 3) != 0), ra, rb);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
